rf_wr_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two producers:
  - the in-order WB stage (final result, destination and write-enable);
  - a long-latency producer (LP), for example the multi-cycle divider or an uncached-load return.
- Sits between WB and the regfile.
- LP results are queued in a small FIFO. They drain on cycles where WB does not write.
- A starvation counter forces a one-cycle pipeline freeze so a waiting LP entry can retire.

---
 rtl/rf_wr_arbiter_pkg.sv | 20 ++
 rtl/rf_wr_arbiter_lp_fifo.sv | 71 +++++++
 rtl/rf_wr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wr_arbiter_pkg.sv
// Shared register-file write definitions: widths, arbiter FSM states and the LP queue entry.
// Imported by the arbiter top level and its LP result FIFO.
package rf_wr_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] dst;
        logic [RF_DATA_W-1:0] data;
    } lp_entry_t;

endpackage

// File: rtl/rf_wr_arbiter_lp_fifo.sv
// Long-latency result queue with per-entry WAW kill against the WB destination.
// Latency: push visible at head one cycle later; pop is same-cycle from head.
// Backpressure: full blocks push unless a pop happens in the same cycle.
module lp_fifo
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 push,
    input  lp_entry_t            push_entry,
    input  logic                 pop,
    input  logic                 kill_vld,
    input  logic [RF_ADDR_W-1:0] kill_dst,
    output lp_entry_t            head,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count
);

    lp_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Kill is applied before the push so a same-cycle enqueue stays valid.
            if (kill_vld) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem_q[i].dst == kill_dst) begin
                        mem_q[i].valid <= 1'b0;
                    end
                end
            end
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter between WB and a long-latency producer, with starvation-forced WB freeze.
// Latency: write mux is combinational; LP results write no earlier than the cycle after enqueue.
// Backpressure: lp_ready drops when the LP FIFO is full and not popping. Optional counters: RF_ARB_PERF_EN.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 wb_we,
    input  logic [RF_ADDR_W-1:0] wb_dst,
    input  logic [RF_DATA_W-1:0] wb_data,
    input  logic                 lp_valid,
    input  logic [RF_ADDR_W-1:0] lp_dst,
    input  logic [RF_DATA_W-1:0] lp_data,
    output logic                 lp_ready,
    output logic                 wb_stall_req,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [RF_DATA_W-1:0] rf_wdata,
    output logic                 lp_pending
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]          perf_force_cnt,
    output logic [31:0]          perf_block_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    arb_state_t       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             lp_pending_q;
    lp_entry_t        head;
    lp_entry_t        push_entry;
    logic             full, empty;
    logic [CNT_W-1:0] count, count_next;
    logic             wb_wr, force_st, lp_sel, wb_grant, head_blocked;
    logic             push, pop, lp_write;

    assign wb_wr        = wb_we && (wb_dst != '0);
    assign force_st     = (state_q == FORCE);
    // The LP head wins when WB is idle or frozen; a flush cycle never retires LP entries.
    assign lp_sel       = !flush && !empty && (force_st || !wb_wr);
    assign wb_grant     = wb_wr && !lp_sel;
    assign head_blocked = !flush && !empty && wb_grant;
    assign pop          = lp_sel;
    assign lp_write     = lp_sel && head.valid;

    assign lp_ready     = !full || pop;
    assign push         = lp_valid && lp_ready && (lp_dst != '0) && !flush;
    assign count_next   = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));

    always_comb begin
        push_entry       = '0;
        push_entry.valid = 1'b1;
        push_entry.dst   = lp_dst;
        push_entry.data  = lp_data;
    end

    lp_fifo #(.DEPTH(DEPTH)) u_lp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_vld   (wb_grant),
        .kill_dst   (wb_dst),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // Reset gating keeps the port quiet while resetn is low even if WB still requests.
    assign rf_we        = resetn && (wb_grant || lp_write);
    assign wb_stall_req = resetn && force_st && !flush;
    assign lp_pending   = lp_pending_q;

    always_comb begin
        rf_waddr = '0;
        rf_wdata = '0;
        if (rf_we) begin
            rf_waddr = wb_grant ? wb_dst  : head.dst;
            rf_wdata = wb_grant ? wb_data : head.data;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (flush) begin
            state_d = IDLE;
            wait_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_d = '0;
                    if (push) begin
                        state_d = PEND;
                    end
                end
                PEND: begin
                    if (count_next == '0) begin
                        state_d = IDLE;
                        wait_d  = '0;
                    end else if (head_blocked) begin
                        if (wait_q == 8'(MAX_WAIT - 1)) begin
                            state_d = FORCE;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + 8'd1;
                        end
                    end else if (pop) begin
                        wait_d = '0;
                    end
                end
                FORCE: begin
                    state_d = (count_next != '0) ? PEND : IDLE;
                    wait_d  = '0;
                end
                default: begin
                    state_d = IDLE;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            lp_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            lp_pending_q <= (count_next != '0);
        end
    end

`ifdef RF_ARB_PERF_EN
    logic [31:0] perf_force_q, perf_block_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_force_q <= '0;
            perf_block_q <= '0;
        end else begin
            if (force_st && (perf_force_q != '1)) begin
                perf_force_q <= perf_force_q + 32'd1;
            end
            if (head_blocked && (perf_block_q != '1)) begin
                perf_block_q <= perf_block_q + 32'd1;
            end
        end
    end

    assign perf_force_cnt = perf_force_q;
    assign perf_block_cnt = perf_block_q;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected regfile writes are queued at stimulus time
// and a negedge monitor compares every presented write against the queue.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        lp_valid;
    logic [4:0]  lp_dst;
    logic [31:0] lp_data;
    logic        lp_ready;
    logic        wb_stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        lp_pending;

    typedef struct {
        logic        stall;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks;
    int  failures;

    rf_wr_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .wb_we        (wb_we),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .lp_valid     (lp_valid),
        .lp_dst       (lp_dst),
        .lp_data      (lp_data),
        .lp_ready     (lp_ready),
        .wb_stall_req (wb_stall_req),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .lp_pending   (lp_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic stall, input logic [4:0] addr, input logic [31:0] data);
        wr_t e;
        e.stall = stall;
        e.addr  = addr;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                       input logic lv, input logic [4:0] ld, input logic [31:0] ldat);
        wb_we    = we;
        wb_dst   = wd;
        wb_data  = wdat;
        lp_valid = lv;
        lp_dst   = ld;
        lp_data  = ldat;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_waddr), 32'(e.addr));
                chk("wr_data", rf_wdata, e.data);
                chk("wr_stall", 32'(wb_stall_req), 32'(e.stall));
            end
        end else if (rf_we !== 1'b0 || wb_stall_req !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL idle_port: got rf_we %b stall %b expected 0 0", rf_we, wb_stall_req);
        end
    end

    initial begin
        clk      = 1'b0;
        resetn   = 1'b0;
        flush    = 1'b0;
        checks   = 0;
        failures = 0;
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #3;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_stall", 32'(wb_stall_req), 32'd0);
        chk("rst_lp_ready", 32'(lp_ready), 32'd1);
        chk("rst_lp_pending", 32'(lp_pending), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        nxt();

        // LP only
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA5555);
        expect_wr(1'b0, 5'd5, 32'hAAAA5555);
        half();
        chk("lp_only_ready", 32'(lp_ready), 32'd1);
        nxt();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        half();
        chk("lp_only_pending", 32'(lp_pending), 32'd1);
        nxt();
        half();
        chk("lp_only_pending_clr", 32'(lp_pending), 32'd0);
        nxt();

        // Contention: 8 blocked cycles, then one forced LP write
        drv(1'b1, 5'd7, 32'h700, 1'b1, 5'd3, 32'h33);
        expect_wr(1'b0, 5'd7, 32'h700);
        nxt();
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, 5'd7, 32'h700 + 32'(i), 1'b0, 5'd0, 32'h0);
            expect_wr(1'b0, 5'd7, 32'h700 + 32'(i));
            nxt();
        end
        drv(1'b1, 5'd7, 32'h708, 1'b0, 5'd0, 32'h0);
        expect_wr(1'b1, 5'd3, 32'h33);
        half();
        chk("contention_force_stall", 32'(wb_stall_req), 32'd1);
        nxt();
        expect_wr(1'b0, 5'd7, 32'h708);
        half();
        chk("contention_resume_stall", 32'(wb_stall_req), 32'd0);
        nxt();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        nxt();

        // WAW kill of an older queued entry
        drv(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
        expect_wr(1'b0, 5'd4, 32'h44);
        nxt();
        drv(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0);
        expect_wr(1'b0, 5'd9, 32'h1);
        nxt();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        half();
        chk("waw_killed_we", 32'(rf_we), 32'd0);
        chk("waw_killed_pending", 32'(lp_pending), 32'd1);
        nxt();
        half();
        chk("waw_drained_pending", 32'(lp_pending), 32'd0);
        nxt();

        // Same-cycle enqueue is newer than the WB write and survives
        drv(1'b1, 5'd12, 32'hB, 1'b1, 5'd12, 32'hC);
        expect_wr(1'b0, 5'd12, 32'hB);
        nxt();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_wr(1'b0, 5'd12, 32'hC);
        nxt();

        // Full FIFO, then pop+push during FORCE
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 5'd7, 32'h800 + 32'(i), 1'b1, 5'(i + 1), 32'h10 + 32'(i));
            expect_wr(1'b0, 5'd7, 32'h800 + 32'(i));
            nxt();
        end
        drv(1'b1, 5'd7, 32'h804, 1'b1, 5'd5, 32'h55);
        expect_wr(1'b0, 5'd7, 32'h804);
        half();
        chk("full_lp_ready", 32'(lp_ready), 32'd0);
        nxt();
        for (int i = 5; i <= 8; i++) begin
            drv(1'b1, 5'd7, 32'h800 + 32'(i), 1'b1, 5'd5, 32'h55);
            expect_wr(1'b0, 5'd7, 32'h800 + 32'(i));
            nxt();
        end
        drv(1'b1, 5'd7, 32'h808, 1'b1, 5'd5, 32'h55);
        expect_wr(1'b1, 5'd1, 32'h10);
        half();
        chk("full_force_stall", 32'(wb_stall_req), 32'd1);
        chk("full_force_ready", 32'(lp_ready), 32'd1);
        nxt();
        drv(1'b1, 5'd7, 32'h808, 1'b0, 5'd0, 32'h0);
        expect_wr(1'b0, 5'd7, 32'h808);
        half();
        chk("full_after_swap_ready", 32'(lp_ready), 32'd0);
        chk("full_after_swap_pending", 32'(lp_pending), 32'd1);
        nxt();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_wr(1'b0, 5'd2, 32'h11);
        expect_wr(1'b0, 5'd3, 32'h12);
        expect_wr(1'b0, 5'd4, 32'h13);
        expect_wr(1'b0, 5'd5, 32'h55);
        for (int i = 0; i < 4; i++) begin
            nxt();
        end
        half();
        chk("full_drained_pending", 32'(lp_pending), 32'd0);
        nxt();

        // Flush with three queued entries and a same-cycle LP push
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 5'd7, 32'h900 + 32'(i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            expect_wr(1'b0, 5'd7, 32'h900 + 32'(i));
            nxt();
        end
        flush = 1'b1;
        drv(1'b1, 5'd7, 32'h97F, 1'b1, 5'd13, 32'hDD);
        expect_wr(1'b0, 5'd7, 32'h97F);
        nxt();
        flush = 1'b0;
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        half();
        chk("flush_pending", 32'(lp_pending), 32'd0);
        chk("flush_no_lp_we", 32'(rf_we), 32'd0);
        nxt();
        half();
        chk("flush_no_lp_we2", 32'(rf_we), 32'd0);
        nxt();

        // Asynchronous reset in the middle of a FORCE cycle
        drv(1'b1, 5'd7, 32'hB00, 1'b1, 5'd6, 32'h66);
        expect_wr(1'b0, 5'd7, 32'hB00);
        nxt();
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, 5'd7, 32'hB00 + 32'(i), 1'b0, 5'd0, 32'h0);
            expect_wr(1'b0, 5'd7, 32'hB00 + 32'(i));
            nxt();
        end
        drv(1'b1, 5'd7, 32'hB08, 1'b0, 5'd0, 32'h0);
        expect_wr(1'b1, 5'd6, 32'h66);
        half();
        chk("pre_reset_force_stall", 32'(wb_stall_req), 32'd1);
        resetn = 1'b0;
        #1;
        chk("async_rst_stall", 32'(wb_stall_req), 32'd0);
        chk("async_rst_rf_we", 32'(rf_we), 32'd0);
        chk("async_rst_lp_ready", 32'(lp_ready), 32'd1);
        chk("async_rst_pending", 32'(lp_pending), 32'd0);
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        nxt();
        half();
        chk("post_reset_pending", 32'(lp_pending), 32'd0);
        chk("post_reset_rf_we", 32'(rf_we), 32'd0);
        nxt();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
